// File: rtl/maple_tx_sequencer.sv
// Maple transmit packet sequencer. It frames a request header, the streamed payload and an XOR
// checksum into the transmitter's byte FIFO interface, then holds off a bus gap before the next request.
module maple_tx_sequencer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [7:0]  req_dest,
  input  logic [7:0]  req_src,
  input  logic [7:0]  req_len,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [31:0] pl_data,
  output logic        tx_enable,
  input  logic        tx_busy,
  output logic        tx_empty,
  output logic [7:0]  tx_data,
  input  logic        tx_next,
  output logic        done,
  output logic        err
);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, GAP} state_t;
  state_t state;

  logic [31:0] hdr, hold;
  logic        hold_vld, sticky;
  logic [10:0] idx, total;
  logic [8:0]  words_left;
  logic [7:0]  csum;
  logic [15:0] gap_cnt;

  logic        pl_acc, adv, is_last, in_hdr, at_csum, underrun, hold_vld_n, stay;
  logic [10:0] idx_n;
  logic [8:0]  words_left_n;
  logic [7:0]  csum_n, next_byte;
  logic [31:0] word_src;

  // tx_data already carries the byte on the wire, so the holding register is free
  // as soon as a word's byte3 has been loaded; the next word may land there at once.
  always_comb begin
    pl_acc       = pl_valid & pl_ready;
    adv          = (state == START || state == STREAM) && tx_next && !tx_empty;
    idx_n        = idx + 11'd1;
    is_last      = idx == total - 11'd1;
    in_hdr       = idx_n < 11'd4;
    at_csum      = idx_n == total - 11'd1;
    csum_n       = csum ^ tx_data;
    word_src     = hold_vld ? hold : pl_data;
    underrun     = adv && !is_last && !in_hdr && !at_csum && idx_n[1:0] == 2'd0 &&
                   !(hold_vld || pl_acc);
    stay         = !(adv && (is_last || underrun));
    if (in_hdr)       next_byte = hdr[{idx_n[1:0], 3'b000} +: 8];
    else if (at_csum) next_byte = csum_n;
    else              next_byte = word_src[{idx_n[1:0], 3'b000} +: 8];
    hold_vld_n   = hold_vld | pl_acc;
    if (adv && !is_last && !in_hdr && !at_csum && idx_n[1:0] == 2'd3) hold_vld_n = 1'b0;
    words_left_n = words_left - {8'd0, pl_acc};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      pl_ready   <= 1'b0;
      tx_enable  <= 1'b0;
      tx_empty   <= 1'b1;
      tx_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      hdr        <= '0;
      hold       <= '0;
      hold_vld   <= 1'b0;
      sticky     <= 1'b0;
      idx        <= '0;
      total      <= '0;
      words_left <= '0;
      csum       <= '0;
      gap_cnt    <= '0;
    end else begin
      tx_enable <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pl_ready  <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          hdr        <= {req_cmd, req_dest, req_src, req_len};
          total      <= {1'b0, req_len, 2'b00} + 11'd5;
          words_left <= {1'b0, req_len};
          idx        <= '0;
          csum       <= '0;
          sticky     <= 1'b0;
          hold_vld   <= 1'b0;
          req_ready  <= 1'b0;
          tx_enable  <= 1'b1;
          tx_empty   <= 1'b0;
          tx_data    <= req_len;
          state      <= START;
        end
        START, STREAM: begin
          state      <= STREAM;
          if (pl_acc) hold <= pl_data;
          hold_vld   <= hold_vld_n;
          words_left <= words_left_n;
          pl_ready   <= stay && words_left_n != 9'd0 && !hold_vld_n;
          if (adv) begin
            idx  <= idx_n;
            csum <= csum_n;
            if (!stay) begin
              tx_empty <= 1'b1;
              tx_data  <= '0;
              state    <= DRAIN;
              if (underrun) sticky <= 1'b1;
            end else begin
              tx_data <= next_byte;
            end
          end
        end
        DRAIN: if (!tx_busy) begin
          done    <= 1'b1;
          err     <= sticky;
          gap_cnt <= '0;
          state   <= GAP;
        end
        // The done cycle is the first GAP cycle; GAP_CYCLES idle cycles follow it.
        GAP: if (gap_cnt == GAP_LAST) begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maple_tx_sequencer.sv
// Bench for maple_tx_sequencer: a randomly paced transmitter and payload source, checked
// against a byte-list frame model (header LSB first, payload words LSB first, XOR checksum).
module tb_maple_tx_sequencer;
  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [7:0]  req_cmd, req_dest, req_src, req_len;
  logic        pl_valid, pl_ready;
  logic [31:0] pl_data;
  logic        tx_enable, tx_busy, tx_empty, tx_next, done, err;
  logic [7:0]  tx_data;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] words [256];
  int          hs_cyc, done_cyc;
  bit          aborted;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maple_tx_sequencer #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_dest(req_dest), .req_src(req_src), .req_len(req_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .tx_enable(tx_enable), .tx_busy(tx_busy), .tx_empty(tx_empty),
    .tx_data(tx_data), .tx_next(tx_next), .done(done), .err(err)
  );

  // Drives one request; offers only the first 'given' payload words. abort_at >= 0 stops
  // the frame while that byte index is on tx_data (caller then applies reset).
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dest, input logic [7:0] src,
                           input logic [7:0] len, input int given, input bit hold_req,
                           input int abort_at);
    logic [7:0] exp_q[$];
    logic [7:0] cs, exp_b;
    int exp_n, exp_pi, bi, pi, en_cnt, done_cnt, tail, stray, t;
    bit ended, got_hs, err_seen, exp_err;
    exp_q = {len, src, dest, cmd};
    for (int w = 0; w < int'(len); w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(words[w][8*b +: 8]);
    cs = 8'h00;
    foreach (exp_q[i]) cs ^= exp_q[i];
    exp_q.push_back(cs);
    exp_err = given < int'(len);
    exp_n   = exp_err ? 4 + 4 * given : exp_q.size();
    exp_pi  = exp_err ? given : int'(len);
    bi = 0; pi = 0; en_cnt = 0; done_cnt = 0; tail = 0; stray = 0; t = 0;
    ended = 0; got_hs = 0; err_seen = 0; aborted = 0;
    req_cmd = cmd; req_dest = dest; req_src = src; req_len = len; req_valid = 1'b1;
    while (done_cnt == 0 && t < 6000) begin
      @(negedge clk);
      t++;
      if (got_hs) req_valid = hold_req;
      else if (req_valid && req_ready) begin got_hs = 1; hs_cyc = cyc; end
      if (tx_enable) begin en_cnt++; tx_busy = 1'b1; end
      if (pl_ready && (pi >= int'(len) || ended)) stray++;
      pl_valid = pi < given && pi < int'(len);
      if (pl_valid) pl_data = words[pi];
      if (pl_valid && pl_ready) pi++;
      tx_next = 1'b0;
      if (tx_busy && !ended && !tx_empty) begin
        if (bi == abort_at) begin aborted = 1; break; end
        exp_b = (bi < exp_q.size()) ? exp_q[bi] : 8'hxx;
        checks++;
        if (bi >= exp_n || tx_data !== exp_b) begin
          errors++;
          $display("FAIL byte%0d: got %h expected %h (frame length %0d)", bi, tx_data, exp_b, exp_n);
        end
        if ($urandom_range(0, 3) != 0) begin tx_next = 1'b1; bi++; end
      end else begin
        if (tx_busy && !ended) begin ended = 1; tail = $urandom_range(0, 3); end
        else if (ended && tx_busy) begin
          if (tail == 0) tx_busy = 1'b0; else tail--;
        end
        tx_next = 1'($urandom_range(0, 1));
      end
      if (done) begin done_cnt++; done_cyc = cyc; err_seen = err; end
      else if (err) stray++;
    end
    pl_valid = 1'b0;
    tx_next  = 1'b0;
    if (aborted) return;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_seen: got %0d pulses expected 1 (timeout %0d cycles)", done_cnt, t); end
    checks++;
    if (en_cnt != 1) begin errors++; $display("FAIL enable_pulses: got %0d expected 1", en_cnt); end
    checks++;
    if (bi != exp_n) begin errors++; $display("FAIL bytes_sent: got %0d expected %0d", bi, exp_n); end
    checks++;
    if (pi != exp_pi) begin errors++; $display("FAIL pl_accepts: got %0d expected %0d", pi, exp_pi); end
    checks++;
    if (err_seen != exp_err) begin errors++; $display("FAIL err_flag: got %0d expected %0d", err_seen, exp_err); end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL stray_ready_or_err: got %0d expected 0", stray); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got done=%b err=%b expected 0 0", done, err); end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL rst_tx_empty: got %b expected 1", tx_empty); end
    checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL rst_tx_enable: got %b expected 0", tx_enable); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    checks++; if (pl_ready !== 1'b0) begin errors++; $display("FAIL rst_pl_ready: got %b expected 0", pl_ready); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err: got %b %b expected 0 0", done, err); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len0;
    run_frame(8'h01, 8'h20, 8'h00, 8'd0, 0, 0, -1);
  endtask

  task automatic test_len1;
    words[0] = 32'h11223344;
    run_frame(8'h01, 8'h20, 8'h00, 8'd1, 1, 0, -1);
  endtask

  task automatic test_underrun;
    words[0] = $urandom; words[1] = $urandom;
    run_frame(8'h01, 8'h20, 8'h00, 8'd2, 1, 0, -1);
  endtask

  task automatic test_reset_mid;
    words[0] = $urandom; words[1] = $urandom;
    run_frame(8'h05, 8'h10, 8'h02, 8'd2, 2, 0, 3);
    checks++; if (!aborted) begin errors++; $display("FAIL abort_reached: got 0 expected 1"); end
    reset = 1'b0;
    #1;
    checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL mid_tx_empty: got %b expected 1", tx_empty); end
    checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL mid_tx_enable: got %b expected 0", tx_enable); end
    checks++; if (pl_ready !== 1'b0) begin errors++; $display("FAIL mid_pl_ready: got %b expected 0", pl_ready); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready: got %b expected 1", req_ready); end
    tx_busy = 1'b0; tx_next = 1'b0; pl_valid = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    words[0] = $urandom; words[1] = $urandom; words[2] = $urandom;
    run_frame(8'h07, 8'h21, 8'h03, 8'd3, 3, 0, -1);
  endtask

  task automatic test_back_to_back;
    int d1;
    words[0] = $urandom;
    run_frame(8'h0a, 8'h40, 8'h01, 8'd1, 1, 1, -1);
    d1 = done_cyc;
    run_frame(8'h0b, 8'h41, 8'h01, 8'd0, 0, 0, -1);
    checks++;
    if (hs_cyc - d1 != GAP + 1) begin
      errors++; $display("FAIL gap_spacing: got %0d cycles expected %0d", hs_cyc - d1, GAP + 1);
    end
  endtask

  task automatic test_long;
    for (int i = 0; i < 256; i++) words[i] = $urandom;
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'd255, 255, 0, -1);
  endtask

  task automatic test_random;
    int len, given;
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(0, 12);
      given = (n % 3 == 2 && len > 0) ? $urandom_range(0, len - 1) : len;
      for (int i = 0; i < len; i++) words[i] = $urandom;
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'(len), given, 0, -1);
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_cmd = '0; req_dest = '0; req_src = '0; req_len = '0;
    pl_valid = 1'b0; pl_data = '0; tx_busy = 1'b0; tx_next = 1'b0;
    test_reset;
    test_len0;
    test_len1;
    test_underrun;
    test_reset_mid;
    test_back_to_back;
    test_long;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
